axis_operand_fork: RTL and testbench
====================================

# axis_operand_fork

Splits one packed AXI-stream operand bundle into C_NUM_CHANNELS independent per-channel AXI-stream operands for the modular-multiplier core's joined operand inputs. Upstream logic writes both operands of a multiplication as one wide beat. The fork buffers the beat and presents slice i on output channel i. Each channel may complete its handshake in a different cycle, and no operand is ever duplicated or dropped.

## Interface
- C_DATA_WIDTH, 256, width of one operand / one output channel
- C_NUM_CHANNELS, 2, number of output channels (≥1)
- FIFO_DEPTH, 2, input buffer depth in beats (power of 2, ≥2)
- CNT_BITS, 32, width of the dispatch counter
- aclk  input  1  clock; all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- s_tvalid  input  1  packed input beat valid
- s_tdata  input  C_NUM_CHANNELS*C_DATA_WIDTH  packed operands; channel i = bits [i*C_DATA_WIDTH +: C_DATA_WIDTH]
- s_tready  output  1  input ready, registered
- m_tvalid  output  C_NUM_CHANNELS  per-channel valid
- m_tdata  output  [C_NUM_CHANNELS][C_DATA_WIDTH]  per-channel operand
- m_tready  input  C_NUM_CHANNELS  per-channel ready
- o_dispatched  output  CNT_BITS  count of beats fully delivered to all channels, wraps

## Operation
- **FIFO:**
  - Circular buffer of FIFO_DEPTH packed beats, with wr_ptr, rd_ptr and occupancy count (log2(FIFO_DEPTH)+1 bits).
  - Write occurs when s_tvalid && s_tready.
- **Head presentation:**
  - m_tdata[i] = slice i of the head entry.
  - m_tvalid[i] = (count != 0) && !done[i].
  - m_tdata is don't-care when m_tvalid[i]=0.
- **Per-channel done bits:**
  - done[i] sets on m_tvalid[i] && m_tready[i].
  - Once done[i] is set, channel i deasserts valid for the rest of that beat.
- **Pop:** when every channel is either done or handshaking this cycle (all_done = &(done | (m_tvalid & m_tready))) and count != 0:
  - rd_ptr increments, wrapping modulo FIFO_DEPTH;
  - all done bits clear;
  - o_dispatched increments, wrapping at 2^CNT_BITS.
- **Simultaneous push and pop:** count is unchanged; both pointers advance.
- **s_tready:** registered. s_tready <= (count_next < FIFO_DEPTH), where count_next includes this cycle's push and pop.
- **Full:** s_tready=0, and the input beat is held by upstream (AXI rule: s_tdata stable while s_tvalid && !s_tready).
- **Empty:**
  - all m_tvalid = 0;
  - done bits are all 0.
- **Reset (async, any time, including mid-beat):**
  - count, pointers, done and o_dispatched all go to 0;
  - s_tready = 0;
  - m_tvalid = 0;
  - partially delivered beats are discarded.
- **Reset values summary:** s_tready=0, m_tvalid=0, o_dispatched=0. FIFO storage is not reset.

## Timing
- **Latency:** an accepted beat at edge N is visible on m_tvalid/m_tdata after edge N (count registered) — 1 cycle, input handshake to output valid.
- **Throughput:** 1 beat/cycle when all m_tready are held high and FIFO_DEPTH ≥ 2.
- **After reset release:** s_tready rises on the first aclk edge with areset low.
- **s_tready vs. occupancy:** s_tready reflects occupancy after the previous edge. A pop in cycle N frees a slot visible as s_tready=1 in cycle N+1.
- **m_tvalid path:** purely from registered state (count, done). No combinational path from m_tready to m_tvalid.
- **All-done path:** a combinational path from m_tready to the pop/all_done logic is permitted.
- **Per-channel timing:** channels are independent. A channel with m_tready held low stalls the pop, but never blocks delivery on other channels of the same beat.

## Test plan
1. **Reset values:** assert areset mid-run with count=2 and done=01 -> same cycle m_tvalid=00; after release, s_tready=0 then 1 next edge; o_dispatched=0.
2. **Single beat:** s_tdata = {B=0x..05, A=0x..03}, all m_tready=1 -> next cycle m_tvalid=11, m_tdata[0]=3, m_tdata[1]=5; o_dispatched=1 after the edge.
3. **Skewed ready:**
   - m_tready[0]=1 from cycle 1; m_tready[1] low until cycle 4.
   - Required: channel 0 handshakes once and m_tvalid[0]=0 for cycles 2–4; channel 1 handshakes at cycle 4.
   - Pop at cycle 4; o_dispatched=1; no duplicate on channel 0.
4. **Back-pressure to full:**
   - All m_tready=0; push 2 beats.
   - Required: s_tready=0 after the second push; the third beat is held.
   - Release m_tready=11 -> beats come out in order, and the third beat is accepted once s_tready returns to 1.
5. **Streaming:** all ready high, 100 random beats back-to-back -> 1 beat/cycle sustained, output order and data match the input, o_dispatched=100.
6. **Counter wrap:** CNT_BITS=4, 17 beats -> o_dispatched=1.

Source files
------------

// File: rtl/axis_operand_fork.sv
// Splits one packed AXI-stream operand beat into C_NUM_CHANNELS independent
// per-channel streams; each channel hands off its slice once per beat.
`timescale 1ns/1ps
module axis_operand_fork #(
   parameter int unsigned C_DATA_WIDTH   = 256,
   parameter int unsigned C_NUM_CHANNELS = 2,
   parameter int unsigned FIFO_DEPTH     = 2,
   parameter int unsigned CNT_BITS       = 32
) (
   input  logic                                          aclk,
   input  logic                                          areset,
   input  logic                                          s_tvalid,
   input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]        s_tdata,
   output logic                                          s_tready,
   output logic [C_NUM_CHANNELS-1:0]                     m_tvalid,
   output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]   m_tdata,
   input  logic [C_NUM_CHANNELS-1:0]                     m_tready,
   output logic [CNT_BITS-1:0]                           o_dispatched
);

   localparam int unsigned BEAT_W = C_NUM_CHANNELS * C_DATA_WIDTH;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W  = PTR_W + 1;

   logic [BEAT_W-1:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [OCC_W-1:0]          count;
   logic [OCC_W-1:0]          count_next;
   logic [C_NUM_CHANNELS-1:0] done;
   logic [C_NUM_CHANNELS-1:0] done_next;
   logic [C_NUM_CHANNELS-1:0] hs;
   logic [BEAT_W-1:0]         head;
   logic                      not_empty;
   logic                      push;
   logic                      pop;
   logic                      all_done;

   // Handshake, join and occupancy logic; m_tvalid depends only on registered state.
   always_comb begin
      not_empty  = (count != '0);
      push       = s_tvalid && s_tready;
      m_tvalid   = not_empty ? ~done : '0;
      hs         = m_tvalid & m_tready;
      all_done   = &(done | hs);
      pop        = all_done && not_empty;
      count_next = count + OCC_W'(push) - OCC_W'(pop);
      done_next  = pop ? '0 : (done | hs);
   end

   // Present the head beat, one slice per channel.
   always_comb begin
      head = mem[rd_ptr];
      for (int unsigned i = 0; i < C_NUM_CHANNELS; i++) begin
         m_tdata[i] = head[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
   end

   // Beat storage is deliberately left unreset.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wr_ptr] <= s_tdata;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         done         <= '0;
         s_tready     <= 1'b0;
         o_dispatched <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr       <= rd_ptr + PTR_W'(1);
            o_dispatched <= o_dispatched + CNT_BITS'(1);
         end
         count    <= count_next;
         done     <= done_next;
         s_tready <= (count_next < OCC_W'(FIFO_DEPTH));
      end
   end

endmodule

// File: tb/tb_axis_operand_fork.sv
// Directed bench for axis_operand_fork: queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_axis_operand_fork;

   localparam int unsigned DW    = 256;
   localparam int unsigned NC    = 2;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned BW    = DW * NC;

   logic                   aclk     = 1'b0;
   logic                   areset   = 1'b0;
   logic                   s_tvalid = 1'b0;
   logic [BW-1:0]          s_tdata  = '0;
   logic [NC-1:0]          m_tready = '0;
   logic                   s_tready;
   logic [NC-1:0]          m_tvalid;
   logic [NC-1:0][DW-1:0]  m_tdata;
   logic [31:0]            o_dispatched;
   logic                   s_tready4;
   logic [NC-1:0]          m_tvalid4;
   logic [NC-1:0][DW-1:0]  m_tdata4;
   logic [3:0]             o_disp4;

   int vectors     = 0;
   int miscompares = 0;

   always #5 aclk = ~aclk;

   axis_operand_fork #(
      .C_DATA_WIDTH(DW), .C_NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH), .CNT_BITS(32)
   ) dut (
      .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
      .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
      .m_tready(m_tready), .o_dispatched(o_dispatched)
   );

   // Narrow-counter copy sharing the same stimulus, for the wrap check.
   axis_operand_fork #(
      .C_DATA_WIDTH(DW), .C_NUM_CHANNELS(NC), .FIFO_DEPTH(DEPTH), .CNT_BITS(4)
   ) dut4 (
      .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
      .s_tready(s_tready4), .m_tvalid(m_tvalid4), .m_tdata(m_tdata4),
      .m_tready(m_tready), .o_dispatched(o_disp4)
   );

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: queue of accepted beats, delivered flags per channel.
   logic [BW-1:0] q[$];
   logic [NC-1:0] mdone    = '0;
   logic          mrdy     = 1'b0;
   int unsigned   mdisp    = 0;
   bit            model_on = 1'b0;
   logic [NC-1:0] mv, mh;
   bit            mpush, mpop;

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         q.delete();
         mdone = '0;
         mrdy  = 1'b0;
         mdisp = 0;
      end else begin
         mpush = s_tvalid && mrdy;
         mv    = (q.size() != 0) ? ~mdone : '0;
         mh    = mv & m_tready;
         mpop  = (q.size() != 0) && ((mdone | mh) == '1);
         if (mpop) begin
            void'(q.pop_front());
            mdone = '0;
            mdisp++;
         end else begin
            mdone = mdone | mh;
         end
         if (mpush) q.push_back(s_tdata);
         mrdy = (q.size() < DEPTH);
      end
   end

   logic [NC-1:0] ev;
   always @(negedge aclk) begin
      if (model_on) begin
         ev = (q.size() != 0) ? ~mdone : '0;
         check("s_tready", BW'(s_tready), BW'(mrdy));
         check("m_tvalid", BW'(m_tvalid), BW'(ev));
         check("m_tvalid_cnt4", BW'(m_tvalid4), BW'(ev));
         for (int i = 0; i < NC; i++) begin
            if (ev[i]) check($sformatf("m_tdata[%0d]", i), BW'(m_tdata[i]), BW'(q[0][i*DW +: DW]));
         end
         check("o_dispatched", BW'(o_dispatched), BW'(mdisp));
         check("o_dispatched_cnt4", BW'(o_disp4), BW'(4'(mdisp)));
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Drive one beat and hold it until the input handshake completes.
   task automatic send(input logic [BW-1:0] d);
      bit acc;
      acc      = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge aclk);
         acc = s_tready;
         @(posedge aclk);
         #1;
      end
      if (!acc) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: got no s_tready expected acceptance within 200 cycles");
      end
      s_tvalid = 1'b0;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      step();
      step();
      areset = 1'b0;
      check("rst_s_tready_low", BW'(s_tready), BW'(0));
      step();
      check("rst_s_tready_high", BW'(s_tready), BW'(1));
   endtask

   function automatic logic [BW-1:0] rnd();
      logic [BW-1:0] r;
      for (int w = 0; w < BW/32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   logic [BW-1:0] b1, b2, b3;
   time           t0;

   initial begin
      // Reset values
      #1 areset = 1'b1;
      @(posedge aclk);
      model_on = 1'b1;
      step();
      check("reset_m_tvalid", BW'(m_tvalid), BW'(0));
      check("reset_s_tready", BW'(s_tready), BW'(0));
      check("reset_disp", BW'(o_dispatched), BW'(0));
      areset = 1'b0;
      check("release_s_tready_low", BW'(s_tready), BW'(0));
      step();
      check("release_s_tready_high", BW'(s_tready), BW'(1));

      // Single beat
      m_tready = 2'b11;
      send({256'h5, 256'h3});
      check("single_valid", BW'(m_tvalid), BW'(2'b11));
      check("single_d0", BW'(m_tdata[0]), BW'(3));
      check("single_d1", BW'(m_tdata[1]), BW'(5));
      step();
      check("single_disp", BW'(o_dispatched), BW'(1));

      // Skewed ready: channel 0 delivers once, channel 1 late
      m_tready = 2'b00;
      send({256'hb2, 256'ha1});
      check("skew_valid0", BW'(m_tvalid), BW'(2'b11));
      m_tready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         step();
         check("skew_ch0_held_off", BW'(m_tvalid), BW'(2'b10));
      end
      check("skew_d1", BW'(m_tdata[1]), BW'(256'hb2));
      m_tready = 2'b11;
      step();
      check("skew_pop_valid", BW'(m_tvalid), BW'(2'b00));
      check("skew_disp", BW'(o_dispatched), BW'(2));

      // Back-pressure to full, third beat held
      b1 = rnd(); b2 = rnd(); b3 = rnd();
      m_tready = 2'b00;
      send(b1);
      send(b2);
      check("full_s_tready", BW'(s_tready), BW'(0));
      s_tvalid = 1'b1;
      s_tdata  = b3;
      step(); step(); step();
      check("full_still_low", BW'(s_tready), BW'(0));
      check("full_head_d0", BW'(m_tdata[0]), BW'(b1[DW-1:0]));
      m_tready = 2'b11;
      send(b3);
      step(); step(); step();
      check("full_drain_valid", BW'(m_tvalid), BW'(0));
      check("full_disp", BW'(o_dispatched), BW'(5));

      // Asynchronous reset mid-beat with two beats queued, channel 0 done
      m_tready = 2'b00;
      send(rnd());
      send(rnd());
      m_tready = 2'b01;
      step();
      m_tready = 2'b00;
      check("mid_partial", BW'(m_tvalid), BW'(2'b10));
      #2 areset = 1'b1;
      #1;
      check("mid_rst_valid", BW'(m_tvalid), BW'(0));
      check("mid_rst_ready", BW'(s_tready), BW'(0));
      check("mid_rst_disp", BW'(o_dispatched), BW'(0));
      step();
      areset = 1'b0;
      check("mid_release_low", BW'(s_tready), BW'(0));
      step();
      check("mid_release_high", BW'(s_tready), BW'(1));
      check("mid_release_valid", BW'(m_tvalid), BW'(0));

      // Streaming 100 beats back-to-back
      m_tready = 2'b11;
      t0 = $time;
      for (int n = 0; n < 100; n++) send(rnd());
      check("stream_cycles", BW'(($time - t0) / 10), BW'(100));
      step(); step(); step();
      check("stream_disp", BW'(o_dispatched), BW'(100));
      check("stream_model_disp", BW'(mdisp), BW'(100));

      // Counter wrap on the 4-bit copy
      do_reset();
      for (int n = 0; n < 17; n++) send(rnd());
      step(); step(); step();
      check("wrap_disp32", BW'(o_dispatched), BW'(17));
      check("wrap_disp4", BW'(o_disp4), BW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
